// File: rtl/bp_cce_lce_req_ingress_pkg.sv
// rtl/bp_cce_lce_req_ingress_pkg.sv - configuration, BedRock LCE request message types and CCE request enums
package bp_cce_lce_req_ingress_pkg;

    typedef enum logic [1:0] {e_bp_default_cfg = 2'd0} bp_params_e;

    localparam int num_lce_p             = 4;
    localparam int paddr_width_p         = 40;
    localparam int lce_id_width_p        = 4;
    localparam int cce_id_width_p        = 4;
    localparam int lce_assoc_p           = 8;
    localparam int dword_width_p         = 64;
    localparam int cce_block_width_p     = 128;
    localparam int coh_noc_max_credits_p = 8;
    localparam int lg_lce_assoc_lp       = $clog2(lce_assoc_p);

    typedef enum logic [3:0] {
        e_bedrock_req_rd    = 4'd0,
        e_bedrock_req_wr    = 4'd1,
        e_bedrock_req_uc_rd = 4'd2,
        e_bedrock_req_uc_wr = 4'd3
    } bp_bedrock_req_type_e;

    typedef enum logic [1:0] {
        e_cce_req_rd,
        e_cce_req_wr,
        e_cce_req_uc_rd,
        e_cce_req_uc_wr
    } bp_cce_req_type_e;

    typedef enum logic [1:0] {e_reset, e_run, e_drop} bp_cce_lce_req_ingress_state_e;

    typedef struct packed {
        logic [lg_lce_assoc_lp-1:0] lru_way_id;
        logic                       non_exclusive;
        logic [lce_id_width_p-1:0]  src_id;
        logic [cce_id_width_p-1:0]  dst_id;
    } bp_bedrock_lce_req_payload_s;

    // msg_type is kept raw so that encodings outside the legal set reach the decoder intact
    typedef struct packed {
        logic [3:0]                  msg_type;
        logic [3:0]                  subop;
        logic [paddr_width_p-1:0]    addr;
        logic [2:0]                  size;
        bp_bedrock_lce_req_payload_s payload;
    } bp_bedrock_lce_req_header_s;

    typedef struct packed {
        bp_bedrock_lce_req_header_s   header;
        logic [cce_block_width_p-1:0] data;
    } bp_bedrock_lce_req_msg_s;

    localparam int lce_req_msg_width_lp = $bits(bp_bedrock_lce_req_msg_s);

    function automatic int bp_num_lce(bp_params_e cfg);
        case (cfg)
            e_bp_default_cfg: bp_num_lce = num_lce_p;
            default:          bp_num_lce = num_lce_p;
        endcase
    endfunction

    function automatic logic bp_lce_req_type_legal(logic [3:0] t);
        case (t)
            e_bedrock_req_rd, e_bedrock_req_wr,
            e_bedrock_req_uc_rd, e_bedrock_req_uc_wr: bp_lce_req_type_legal = 1'b1;
            default:                                  bp_lce_req_type_legal = 1'b0;
        endcase
    endfunction

    function automatic bp_cce_req_type_e bp_cce_decode_req_type(logic [3:0] t);
        case (t)
            e_bedrock_req_wr:    bp_cce_decode_req_type = e_cce_req_wr;
            e_bedrock_req_uc_rd: bp_cce_decode_req_type = e_cce_req_uc_rd;
            e_bedrock_req_uc_wr: bp_cce_decode_req_type = e_cce_req_uc_wr;
            default:             bp_cce_decode_req_type = e_cce_req_rd;
        endcase
    endfunction

endpackage

// File: rtl/bp_cce_lce_req_ingress_credit_tracker.sv
// rtl/bp_cce_lce_req_ingress_credit_tracker.sv - per-LCE outstanding request counters with sticky overflow/underflow
module bp_cce_lce_credit_tracker
    import bp_cce_lce_req_ingress_pkg::*;
#(
    parameter int els_p      = 4,
    parameter int id_width_p = 4,
    parameter int credits_p  = 8
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  inc_v_i,
    input  logic [id_width_p-1:0] inc_id_i,
    input  logic                  dec_v_i,
    input  logic [id_width_p-1:0] dec_id_i,
    output logic                  bad_id_o,
    output logic                  overflow_o,
    output logic                  underflow_o
);

    localparam int cnt_width_lp = $clog2(credits_p + 1);
    localparam logic [cnt_width_lp-1:0] cnt_max_lp = cnt_width_lp'(credits_p);

    logic [cnt_width_lp-1:0] cnt_r [els_p];
    logic [els_p-1:0]        inc_hit, dec_hit, at_max, at_zero;
    logic                    inc_ok, dec_ok, overflow_r, underflow_r;

    assign inc_ok   = {1'b0, inc_id_i} < (id_width_p + 1)'(els_p);
    assign dec_ok   = {1'b0, dec_id_i} < (id_width_p + 1)'(els_p);
    assign bad_id_o = (inc_v_i & ~inc_ok) | (dec_v_i & ~dec_ok);

    always_comb begin
        inc_hit = '0;
        dec_hit = '0;
        at_max  = '0;
        at_zero = '0;
        for (int i = 0; i < els_p; i++) begin
            inc_hit[i] = inc_v_i & inc_ok & (inc_id_i == id_width_p'(i));
            dec_hit[i] = dec_v_i & dec_ok & (dec_id_i == id_width_p'(i));
            at_max[i]  = cnt_r[i] == cnt_max_lp;
            at_zero[i] = cnt_r[i] == '0;
        end
    end

    // An increment and a decrement on the same LCE cancel, including at the limits
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < els_p; i++) begin
                cnt_r[i] <= '0;
            end
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            for (int i = 0; i < els_p; i++) begin
                if (inc_hit[i] & ~dec_hit[i] & ~at_max[i]) begin
                    cnt_r[i] <= cnt_r[i] + 1'b1;
                end else if (dec_hit[i] & ~inc_hit[i] & ~at_zero[i]) begin
                    cnt_r[i] <= cnt_r[i] - 1'b1;
                end
            end
            if (|(inc_hit & ~dec_hit & at_max)) begin
                overflow_r <= 1'b1;
            end
            if (|(dec_hit & ~inc_hit & at_zero)) begin
                underflow_r <= 1'b1;
            end
        end
    end

    assign overflow_o  = overflow_r;
    assign underflow_o = underflow_r;

endmodule

// File: rtl/bp_cce_lce_req_ingress.sv
// rtl/bp_cce_lce_req_ingress.sv - CCE receiver for LCE requests: buffering, head decode, credit checking
module bp_cce_lce_req_ingress
    import bp_cce_lce_req_ingress_pkg::*;
#(
    parameter bp_params_e bp_params_p  = e_bp_default_cfg,
    parameter int         credits_p    = coh_noc_max_credits_p,
    parameter int         buffer_els_p = 2
) (
    input  logic                            clk_i,
    input  logic                            reset_i,
    input  logic [cce_id_width_p-1:0]       cce_id_i,
    input  logic [lce_req_msg_width_lp-1:0] lce_req_i,
    input  logic                            lce_req_v_i,
    output logic                            lce_req_ready_o,
    output logic                            req_v_o,
    input  logic                            req_yumi_i,
    output logic [1:0]                      req_type_o,
    output logic [lce_id_width_p-1:0]       req_lce_id_o,
    output logic [paddr_width_p-1:0]        req_addr_o,
    output logic [2:0]                      req_size_o,
    output logic [lg_lce_assoc_lp-1:0]      req_lru_way_o,
    output logic                            req_non_excl_o,
    output logic [dword_width_p-1:0]        req_data_o,
    output logic                            req_misroute_o,
    input  logic                            req_complete_i,
    input  logic [lce_id_width_p-1:0]       req_complete_lce_id_i,
    output logic                            credit_overflow_o,
    output logic                            credit_underflow_o,
    output logic                            bad_type_o
);

    localparam int num_lce_lp = bp_num_lce(bp_params_p);
    localparam int ptr_width_lp = (buffer_els_p > 1) ? $clog2(buffer_els_p) : 1;
    localparam int cnt_width_lp = $clog2(buffer_els_p + 1);
    localparam logic [ptr_width_lp-1:0] last_ptr_lp = ptr_width_lp'(buffer_els_p - 1);

    bp_bedrock_lce_req_msg_s       mem_r [buffer_els_p];
    bp_bedrock_lce_req_msg_s       head;
    logic [ptr_width_lp-1:0]       rptr_r, wptr_r;
    logic [cnt_width_lp-1:0]       count_r;
    logic                          fifo_full, head_v, head_legal;
    logic                          enq, deq, ready, req_v, drop, bad_head;
    logic                          bad_type_r, trk_bad_id;
    bp_cce_lce_req_ingress_state_e state_r, state_n;

    assign fifo_full  = count_r == cnt_width_lp'(buffer_els_p);
    assign head_v     = count_r != '0;
    assign head       = mem_r[rptr_r];
    assign head_legal = bp_lce_req_type_legal(head.header.msg_type);

    assign enq = lce_req_v_i & ready;
    assign deq = (req_v & req_yumi_i) | drop;

    always_ff @(posedge clk_i) begin
        if (enq) begin
            mem_r[wptr_r] <= lce_req_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rptr_r  <= '0;
            wptr_r  <= '0;
            count_r <= '0;
        end else begin
            if (enq) begin
                wptr_r <= (wptr_r == last_ptr_lp) ? '0 : wptr_r + 1'b1;
            end
            if (deq) begin
                rptr_r <= (rptr_r == last_ptr_lp) ? '0 : rptr_r + 1'b1;
            end
            case ({enq, deq})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r <= e_reset;
        end else begin
            state_r <= state_n;
        end
    end

    // ready comes from registered state (plus reset) so the LCE may derive valid from it
    always_comb begin
        state_n  = state_r;
        ready    = 1'b0;
        req_v    = 1'b0;
        drop     = 1'b0;
        bad_head = 1'b0;
        case (state_r)
            e_reset: state_n = e_run;
            e_run: begin
                ready    = ~fifo_full;
                req_v    = head_v & head_legal;
                bad_head = head_v & ~head_legal;
                if (bad_head) begin
                    state_n = e_drop;
                end
            end
            e_drop: begin
                ready   = ~fifo_full;
                drop    = head_v;
                state_n = e_run;
            end
            default: state_n = e_reset;
        endcase
        if (reset_i) begin
            ready    = 1'b0;
            req_v    = 1'b0;
            drop     = 1'b0;
            bad_head = 1'b0;
        end
    end

    assign lce_req_ready_o = ready;
    assign req_v_o         = req_v;

    always_comb begin
        req_type_o     = '0;
        req_lce_id_o   = '0;
        req_addr_o     = '0;
        req_size_o     = '0;
        req_lru_way_o  = '0;
        req_non_excl_o = 1'b0;
        req_data_o     = '0;
        req_misroute_o = 1'b0;
        if (req_v) begin
            req_type_o     = bp_cce_decode_req_type(head.header.msg_type);
            req_lce_id_o   = head.header.payload.src_id;
            req_addr_o     = head.header.addr;
            req_size_o     = head.header.size;
            req_lru_way_o  = head.header.payload.lru_way_id;
            req_non_excl_o = head.header.payload.non_exclusive;
            req_data_o     = head.data[dword_width_p-1:0];
            req_misroute_o = head.header.payload.dst_id != cce_id_i;
        end
    end

    logic unused_head;
    assign unused_head = ^{head.header.subop, head.data[cce_block_width_p-1:dword_width_p]};

    bp_cce_lce_credit_tracker #(
        .els_p      (num_lce_lp),
        .id_width_p (lce_id_width_p),
        .credits_p  (credits_p)
    ) credit_tracker (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .inc_v_i     (req_v & req_yumi_i),
        .inc_id_i    (head.header.payload.src_id),
        .dec_v_i     (req_complete_i),
        .dec_id_i    (req_complete_lce_id_i),
        .bad_id_o    (trk_bad_id),
        .overflow_o  (credit_overflow_o),
        .underflow_o (credit_underflow_o)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            bad_type_r <= 1'b0;
        end else if (bad_head | trk_bad_id) begin
            bad_type_r <= 1'b1;
        end
    end

    assign bad_type_o = bad_type_r;

endmodule

// File: tb/tb_bp_cce_lce_req_ingress.sv
// tb/tb_bp_cce_lce_req_ingress.sv - scoreboard bench for the CCE LCE request ingress
module tb_bp_cce_lce_req_ingress;
    import bp_cce_lce_req_ingress_pkg::*;

    localparam int credits_lp = 2;
    localparam int buffer_els_lp = 2;
    localparam int max_id_lp = (1 << lce_id_width_p) - 1;
    localparam logic [cce_id_width_p-1:0] my_cce_lp = cce_id_width_p'(2);

    logic                            clk = 1'b0;
    logic                            reset = 1'b1;
    logic [lce_req_msg_width_lp-1:0] lce_req = '0;
    logic                            lce_req_v = 1'b0;
    logic                            lce_req_ready;
    logic                            req_v;
    logic                            req_yumi = 1'b0;
    logic [1:0]                      req_type;
    logic [lce_id_width_p-1:0]       req_lce_id;
    logic [paddr_width_p-1:0]        req_addr;
    logic [2:0]                      req_size;
    logic [lg_lce_assoc_lp-1:0]      req_lru_way;
    logic                            req_non_excl;
    logic [dword_width_p-1:0]        req_data;
    logic                            req_misroute;
    logic                            req_complete = 1'b0;
    logic [lce_id_width_p-1:0]       req_complete_lce_id = '0;
    logic                            credit_overflow, credit_underflow, bad_type;

    always #5 clk = ~clk;

    bp_cce_lce_req_ingress #(
        .bp_params_p  (e_bp_default_cfg),
        .credits_p    (credits_lp),
        .buffer_els_p (buffer_els_lp)
    ) dut (
        .clk_i                 (clk),
        .reset_i               (reset),
        .cce_id_i              (my_cce_lp),
        .lce_req_i             (lce_req),
        .lce_req_v_i           (lce_req_v),
        .lce_req_ready_o       (lce_req_ready),
        .req_v_o               (req_v),
        .req_yumi_i            (req_yumi),
        .req_type_o            (req_type),
        .req_lce_id_o          (req_lce_id),
        .req_addr_o            (req_addr),
        .req_size_o            (req_size),
        .req_lru_way_o         (req_lru_way),
        .req_non_excl_o        (req_non_excl),
        .req_data_o            (req_data),
        .req_misroute_o        (req_misroute),
        .req_complete_i        (req_complete),
        .req_complete_lce_id_i (req_complete_lce_id),
        .credit_overflow_o     (credit_overflow),
        .credit_underflow_o    (credit_underflow),
        .bad_type_o            (bad_type)
    );

    int checks = 0;
    int errors = 0;

    // stimulus knobs and queues
    int send_pct = 0, yumi_pct = 0, cmpl_pct = 0, bad_pct = 0, oor_pct = 0;
    bit rst_req = 1'b1;
    bit mon_en = 1'b0;
    bp_bedrock_lce_req_msg_s stim_q[$];
    int cmpl_q[$];

    // reference model: buffered messages, per-LCE outstanding counts, sticky flags
    bp_bedrock_lce_req_msg_s fifo_m[$];
    int cnt_m [num_lce_p];
    bit ovf_m = 0, udf_m = 0, bad_m = 0, after_reset_m = 0, bad_seen_m = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit type_ok(logic [3:0] t);
        return t inside {e_bedrock_req_rd, e_bedrock_req_wr, e_bedrock_req_uc_rd, e_bedrock_req_uc_wr};
    endfunction

    function automatic logic [1:0] exp_cce_type(logic [3:0] t);
        case (t)
            e_bedrock_req_rd:    return 2'(e_cce_req_rd);
            e_bedrock_req_wr:    return 2'(e_cce_req_wr);
            e_bedrock_req_uc_rd: return 2'(e_cce_req_uc_rd);
            default:             return 2'(e_cce_req_uc_wr);
        endcase
    endfunction

    function automatic bp_bedrock_lce_req_msg_s mk(input logic [3:0] t, input int src,
            input logic [paddr_width_p-1:0] addr, input int way,
            input logic [dword_width_p-1:0] dw, input logic [cce_id_width_p-1:0] dst);
        bp_bedrock_lce_req_msg_s m;
        m = '0;
        m.header.msg_type              = t;
        m.header.subop                 = 4'($urandom);
        m.header.addr                  = addr;
        m.header.size                  = 3'($urandom_range(7));
        m.header.payload.lru_way_id    = lg_lce_assoc_lp'(way);
        m.header.payload.non_exclusive = 1'($urandom);
        m.header.payload.src_id        = lce_id_width_p'(src);
        m.header.payload.dst_id        = dst;
        m.data = {(cce_block_width_p - dword_width_p)'({$urandom, $urandom}), dw};
        return m;
    endfunction

    function automatic bp_bedrock_lce_req_msg_s rand_msg();
        logic [3:0] t;
        int src;
        logic [cce_id_width_p-1:0] dst;
        t   = (int'($urandom_range(99)) < bad_pct) ? 4'($urandom_range(15, 4)) : 4'($urandom_range(3));
        src = (int'($urandom_range(99)) < oor_pct) ? int'($urandom_range(max_id_lp, num_lce_p))
                                                   : int'($urandom_range(num_lce_p - 1));
        dst = (int'($urandom_range(3)) == 0) ? cce_id_width_p'($urandom) : my_cce_lp;
        return mk(t, src, paddr_width_p'({$urandom, $urandom}), int'($urandom_range(lce_assoc_p - 1)),
                  {$urandom, $urandom}, dst);
    endfunction

    task automatic drive_cycle();
        @(posedge clk);
        #1;
        reset = rst_req;
        req_complete = 1'b0;
        if (cmpl_q.size() > 0) begin
            req_complete = 1'b1;
            req_complete_lce_id = lce_id_width_p'(cmpl_q.pop_front());
        end else if (int'($urandom_range(99)) < cmpl_pct) begin
            req_complete = 1'b1;
            req_complete_lce_id = (int'($urandom_range(99)) < oor_pct)
                ? lce_id_width_p'($urandom_range(max_id_lp, num_lce_p))
                : lce_id_width_p'($urandom_range(num_lce_p - 1));
        end
        if (stim_q.size() == 0 && int'($urandom_range(99)) < send_pct) begin
            stim_q.push_back(rand_msg());
        end
        #1;
        lce_req_v = 1'b0;
        if (stim_q.size() > 0 && lce_req_ready) begin
            lce_req = stim_q.pop_front();
            lce_req_v = 1'b1;
        end
        req_yumi = req_v && (int'($urandom_range(99)) < yumi_pct);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) drive_cycle();
    endtask

    task automatic apply_reset(input int n);
        rst_req = 1'b1;
        run(n);
        rst_req = 1'b0;
    endtask

    // outputs reflect all edges so far; inputs now held are applied to the model for the next edge
    task automatic monitor_step();
        bp_bedrock_lce_req_msg_s h;
        bit have_head, head_ok, exp_v, exp_ready, inc_v, dec_v;
        int inc_id, dec_id;
        have_head = fifo_m.size() > 0;
        h = have_head ? fifo_m[0] : '0;
        head_ok   = have_head && type_ok(h.header.msg_type);
        exp_v     = !reset && !after_reset_m && head_ok;
        exp_ready = !reset && !after_reset_m && (fifo_m.size() < buffer_els_lp);

        check("lce_req_ready", 128'(lce_req_ready), 128'(exp_ready));
        check("req_v", 128'(req_v), 128'(exp_v));
        check("credit_overflow", 128'(credit_overflow), 128'(ovf_m));
        check("credit_underflow", 128'(credit_underflow), 128'(udf_m));
        check("bad_type", 128'(bad_type), 128'(bad_m));
        if (exp_v && req_v) begin
            check("req_type", 128'(req_type), 128'(exp_cce_type(h.header.msg_type)));
            check("req_lce_id", 128'(req_lce_id), 128'(h.header.payload.src_id));
            check("req_addr", 128'(req_addr), 128'(h.header.addr));
            check("req_size", 128'(req_size), 128'(h.header.size));
            check("req_lru_way", 128'(req_lru_way), 128'(h.header.payload.lru_way_id));
            check("req_non_excl", 128'(req_non_excl), 128'(h.header.payload.non_exclusive));
            check("req_data", 128'(req_data), 128'(h.data[dword_width_p-1:0]));
            check("req_misroute", 128'(req_misroute), 128'(h.header.payload.dst_id != my_cce_lp));
        end

        if (reset) begin
            fifo_m.delete();
            foreach (cnt_m[i]) cnt_m[i] = 0;
            ovf_m = 0;
            udf_m = 0;
            bad_m = 0;
            bad_seen_m = 0;
            after_reset_m = 1;
        end else begin
            after_reset_m = 0;
            inc_v = 0;
            inc_id = 0;
            if (have_head && !head_ok) begin
                // a bad head is visible for one cycle, then discarded during the following one
                if (bad_seen_m) begin
                    void'(fifo_m.pop_front());
                    bad_seen_m = 0;
                end else begin
                    bad_seen_m = 1;
                    bad_m = 1;
                end
            end else if (exp_v && req_yumi) begin
                inc_v = 1;
                inc_id = int'(h.header.payload.src_id);
                void'(fifo_m.pop_front());
            end
            dec_v = req_complete;
            dec_id = int'(req_complete_lce_id);
            if (inc_v && inc_id >= num_lce_p) begin
                bad_m = 1;
                inc_v = 0;
            end
            if (dec_v && dec_id >= num_lce_p) begin
                bad_m = 1;
                dec_v = 0;
            end
            if (!(inc_v && dec_v && inc_id == dec_id)) begin
                if (inc_v) begin
                    if (cnt_m[inc_id] == credits_lp) ovf_m = 1;
                    else cnt_m[inc_id]++;
                end
                if (dec_v) begin
                    if (cnt_m[dec_id] == 0) udf_m = 1;
                    else cnt_m[dec_id]--;
                end
            end
            if (lce_req_v && exp_ready) begin
                fifo_m.push_back(bp_bedrock_lce_req_msg_s'(lce_req));
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) monitor_step();
    end

    initial begin
        foreach (cnt_m[i]) cnt_m[i] = 0;
        drive_cycle();
        mon_en = 1'b1;
        apply_reset(2);

        // single rd from LCE 1, consumed on arrival
        yumi_pct = 100;
        stim_q.push_back(mk(e_bedrock_req_rd, 1, paddr_width_p'(40'h0_8000_0040), 3, '0, my_cce_lp));
        run(5);

        // three uc_wr with the consumer stalled: buffer fills, then drains in order
        yumi_pct = 0;
        for (int i = 0; i < 3; i++)
            stim_q.push_back(mk(e_bedrock_req_uc_wr, 2, paddr_width_p'(64 * i), i,
                                dword_width_p'(64'hDEAD_BEEF), my_cce_lp));
        run(5);
        yumi_pct = 100;
        run(6);

        // LCE 0 exceeds two outstanding requests
        for (int i = 0; i < 3; i++)
            stim_q.push_back(mk(e_bedrock_req_rd, 0, paddr_width_p'(128 * i), 0, '0, my_cce_lp));
        run(8);

        // LCE 1 holds one request: first completion is legal, second underflows
        cmpl_q.push_back(1);
        cmpl_q.push_back(1);
        run(4);

        // illegal type followed by a wr
        stim_q.push_back(mk(4'h9, 1, paddr_width_p'(40'h100), 1, '0, my_cce_lp));
        stim_q.push_back(mk(e_bedrock_req_wr, 1, paddr_width_p'(40'h140), 2, '0, my_cce_lp));
        run(8);

        // reset while two requests are buffered and counters are nonzero
        apply_reset(1);
        stim_q.push_back(mk(e_bedrock_req_rd, 3, paddr_width_p'(40'h200), 0, '0, my_cce_lp));
        run(4);
        yumi_pct = 0;
        stim_q.push_back(mk(e_bedrock_req_wr, 3, paddr_width_p'(40'h240), 1, '0, my_cce_lp));
        stim_q.push_back(mk(e_bedrock_req_wr, 2, paddr_width_p'(40'h280), 1, '0, my_cce_lp));
        run(4);
        apply_reset(1);
        cmpl_q.push_back(3);
        run(4);

        // randomized rounds, each ending in a reset with traffic in flight
        for (int r = 0; r < 6; r++) begin
            send_pct = int'($urandom_range(40, 95));
            yumi_pct = int'($urandom_range(20, 90));
            cmpl_pct = int'($urandom_range(5, 40));
            bad_pct  = (r == 0) ? 0 : 8;
            oor_pct  = (r < 2) ? 0 : 4;
            run(250);
            apply_reset(1 + (r % 2));
        end
        send_pct = 0;
        cmpl_pct = 0;
        yumi_pct = 100;
        run(10);

        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bp_cce_lce_req_ingress.md
Name: bp_cce_lce_req_ingress

Overview:
- CCE-side receiver for BedRock LCE request messages: the responder end of the LCE request channel.
- Accepts requests from the coherence NoC and buffers them in a 2-entry FIFO.
- Decodes the head entry into fields for the CCE pipeline.
- Tracks outstanding requests per LCE against the LCE credit limit and flags protocol violations.

Parameters:
- bp_params_p, e_bp_default_cfg, processor configuration; supplies num_lce_p, paddr_width_p, lce_id_width_p, cce_id_width_p, lce_assoc_p, dword_width_p, cce_block_width_p.
- credits_p, coh_noc_max_credits_p, maximum outstanding requests per LCE.
- buffer_els_p, 2, request FIFO depth; minimum 2.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous active-high reset
- cce_id_i  in  cce_id_width_p  this CCE's id
- lce_req_i  in  lce_req_msg_width_lp  BedRock LCE request message
- lce_req_v_i  in  1  message valid; the LCE drives it only in a cycle where lce_req_ready_o=1
- lce_req_ready_o  out  1  space available
- req_v_o  out  1  decoded request valid
- req_yumi_i  in  1  CCE consumes head; legal only when req_v_o=1
- req_type_o  out  2  bp_cce_req_type_e of head
- req_lce_id_o  out  lce_id_width_p  head src_id
- req_addr_o  out  paddr_width_p  head address
- req_size_o  out  3  head msg size
- req_lru_way_o  out  lg lce_assoc_p  head lru_way_id
- req_non_excl_o  out  1  head non_exclusive
- req_data_o  out  dword_width_p  head data[dword_width_p-1:0]; meaningful for uc_wr only
- req_misroute_o  out  1  head dst_id != cce_id_i
- req_complete_i  in  1  one request of req_complete_lce_id_i has finished
- req_complete_lce_id_i  in  lce_id_width_p  LCE whose request finished
- credit_overflow_o  out  1  sticky error
- credit_underflow_o  out  1  sticky error
- bad_type_o  out  1  sticky error

Behaviour:
- Reset: all outputs 0, FIFO empty, all per-LCE counters 0, sticky errors cleared. Reset mid-operation flushes buffered requests with no completion side effects.
- lce_req_ready_o = ~reset_i & ~fifo_full. It depends on registered state only, never on lce_req_v_i or req_yumi_i, so the LCE may assert valid combinationally from ready.
- Enqueue when lce_req_v_i & lce_req_ready_o. Enqueue and dequeue in the same cycle are legal at any occupancy below full.
- Latency: a request written at edge N appears on req_v_o/fields in cycle N+1. Fields are combinational decode of the FIFO head and stay stable while req_v_o=1 and no yumi.
- Type decode: e_bedrock_req_rd→e_cce_req_rd, wr→wr, uc_rd→uc_rd, uc_wr→uc_wr.
- Any other msg_type at the head:
  - req_v_o held 0;
  - entry auto-dropped the next cycle;
  - bad_type_o set;
  - no counter increment.
- req_misroute_o is informational; the request is still presented.
- Per-LCE counter, width `BSG_WIDTH(credits_p)`:
  - +1 on req_yumi_i for the head's src_id;
  - -1 on req_complete_i for req_complete_lce_id_i;
  - both on the same LCE in one cycle: no change.
- Counter at credits_p on increment: saturate, set credit_overflow_o.
- Counter at 0 on decrement: hold 0, set credit_underflow_o.
- src_id or complete id >= num_lce_p: set bad_type_o, no counter update.
- Sticky errors clear only on reset.
- FSM states:
  - e_reset: one cycle after reset deassertion; ready=0.
  - e_run: normal operation.
  - e_drop: one cycle discarding a bad-type head; ready follows FIFO state.
- Transitions: e_reset→e_run; e_run→e_drop when head valid with bad type; e_drop→e_run.

Decomposition:
- Shared package (bp_me_pkg): bp_cce_req_type_e {e_cce_req_rd, e_cce_req_wr, e_cce_req_uc_rd, e_cce_req_uc_wr}.
- Message structs come from the existing declare_bp_bedrock_lce_if macro.
- FIFO: bsg_fifo_1r1w_small.
- One natural sub-module: bp_cce_lce_credit_tracker. It holds the num_lce_p counters, increment/decrement ports, and overflow/underflow flags.

Test Plan:
- Reset, then send rd from LCE 1 addr 0x8000_0040 lru_way 3 with dst=cce_id_i → cycle+1: req_v_o=1, type rd, lce 1, way 3, misroute 0; after yumi, LCE1 count=1.
- Three back-to-back uc_wr with no yumi → first two accepted, lce_req_ready_o=0 after second; yumi one → ready=1 next cycle, third accepted; data 0xDEADBEEF preserved in order.
- credits_p=2: yumi three requests from LCE 0 with no completions → count saturates at 2, credit_overflow_o=1 and remains 1.
- Same cycle yumi (LCE 0) and req_complete_i (LCE 0) at count 1 → count stays 1; complete for LCE 1 at count 0 → credit_underflow_o=1.
- Inject msg_type outside the four legal encodings followed by a valid wr → bad_type_o=1, no req_v_o for the bad entry, the wr is presented two cycles after the bad entry reached the head.
- Assert reset with 2 entries buffered and counts nonzero → next cycle after reset: req_v_o=0, all counters 0, errors 0, ready=0 in e_reset, then 1.
